// File: rtl/ball_motion.sv
// Pong ball engine: owns the ball position, bounces it off paddles and walls on
// internal step strobes, detects misses, keeps score and sequences serve/play/point/game-over.
module ball_motion #(
    parameter int STEP_DIV    = 4,
    parameter int SERVE_DELAY = 3,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serve,
    input  logic [1:0] paddle_collision,
    input  logic       wall_collision,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       point1,
    output logic       point2,
    output logic       game_over,
    output logic       playing
);

    typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_e;

    localparam int CW = $clog2(STEP_DIV);
    localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [5:0]    CENTRE     = 6'd31;
    localparam logic [5:0]    X_MIN      = 6'd2;
    localparam logic [5:0]    X_MAX      = 6'd61;
    localparam logic [5:0]    Y_MAX      = 6'd63;
    localparam logic [2:0]    WIN        = 3'(WIN_SCORE);
    localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [1:0]    HIT_LEFT   = 2'b01;
    localparam logic [1:0]    HIT_RIGHT  = 2'b11;

    state_e          state_q, state_d;
    logic [5:0]      bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;   // dx: 1 = right, dy: 1 = down
    logic [2:0]      score1_q, score1_d, score2_q, score2_d;
    logic            point1_q, point1_d, point2_q, point2_d;
    logic [CW-1:0]   step_cnt_q, step_cnt_d;
    logic [DW-1:0]   delay_cnt_q, delay_cnt_d;
    logic            playing_q, game_over_q;
    logic            step, miss_left, miss_right, dx_nx, dy_nx;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        point1_d    = 1'b0;
        point2_d    = 1'b0;
        delay_cnt_d = delay_cnt_q;

        step = (state_q == PLAY || state_q == MISS) && (step_cnt_q == STEP_LAST);
        if (state_q == PLAY || state_q == MISS)
            step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
        else
            step_cnt_d = '0;

        miss_left  = (bx_q == X_MIN) && !dx_q && (paddle_collision != HIT_LEFT);
        miss_right = (bx_q == X_MAX) &&  dx_q && (paddle_collision != HIT_RIGHT);

        // A paddle flag only flips dx when it opposes travel, so a held flag cannot double-bounce.
        dx_nx = dx_q;
        if (paddle_collision == HIT_LEFT && !dx_q)
            dx_nx = 1'b1;
        else if (paddle_collision == HIT_RIGHT && dx_q)
            dx_nx = 1'b0;

        dy_nx = dy_q;
        if (wall_collision && by_q == 6'd0)
            dy_nx = 1'b1;
        else if (wall_collision && by_q == Y_MAX)
            dy_nx = 1'b0;

        case (state_q)
            IDLE: begin
                bx_d = CENTRE;
                by_d = CENTRE;
                if (serve) state_d = PLAY;
            end
            PLAY: if (step) begin
                if (miss_left) begin
                    score2_d    = (score2_q < WIN) ? score2_q + 3'd1 : score2_q;
                    point2_d    = 1'b1;
                    delay_cnt_d = '0;
                    state_d     = MISS;
                end else if (miss_right) begin
                    score1_d    = (score1_q < WIN) ? score1_q + 3'd1 : score1_q;
                    point1_d    = 1'b1;
                    delay_cnt_d = '0;
                    state_d     = MISS;
                end else begin
                    dx_d = dx_nx;
                    dy_d = dy_nx;
                    bx_d = dx_nx ? bx_q + 6'd1 : bx_q - 6'd1;
                    by_d = dy_nx ? by_q + 6'd1 : by_q - 6'd1;
                end
            end
            MISS: if (step) begin
                // dx is left untouched: at a miss it already points at the player who lost.
                if (delay_cnt_q == DELAY_LAST) begin
                    bx_d        = CENTRE;
                    by_d        = CENTRE;
                    dy_d        = 1'b1;
                    delay_cnt_d = '0;
                    state_d     = (score1_q == WIN || score2_q == WIN) ? OVER : IDLE;
                end else begin
                    delay_cnt_d = delay_cnt_q + 1'b1;
                end
            end
            OVER: begin
                bx_d = CENTRE;
                by_d = CENTRE;
                if (serve) begin
                    score1_d = '0;
                    score2_d = '0;
                    dx_d     = 1'b1;
                    dy_d     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bx_q        <= CENTRE;
            by_q        <= CENTRE;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score1_q    <= '0;
            score2_q    <= '0;
            point1_q    <= 1'b0;
            point2_q    <= 1'b0;
            step_cnt_q  <= '0;
            delay_cnt_q <= '0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            point1_q    <= point1_d;
            point2_q    <= point2_d;
            step_cnt_q  <= step_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            playing_q   <= (state_d == PLAY);
            game_over_q <= (state_d == OVER);
        end
    end

    assign bx        = bx_q;
    assign by        = by_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point1    = point1_q;
    assign point2    = point2_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: steers the ball through bounces, misses, a full game
// and a mid-play reset, checking hand-computed positions, scores and pulses.
module tb_ball_motion;

    localparam int STEP_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serve = 1'b0;
    logic [1:0] paddle_collision = 2'b00;
    logic       wall_collision = 1'b0;
    logic [5:0] bx, by;
    logic [2:0] score1, score2;
    logic       point1, point2, game_over, playing;

    int checks = 0;
    int errors = 0;

    ball_motion #(.STEP_DIV(STEP_DIV), .SERVE_DELAY(3), .WIN_SCORE(7)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .serve            (serve),
        .paddle_collision (paddle_collision),
        .wall_collision   (wall_collision),
        .bx               (bx),
        .by               (by),
        .score1           (score1),
        .score2           (score2),
        .point1           (point1),
        .point2           (point2),
        .game_over        (game_over),
        .playing          (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_bx"}, 32'(bx), 32'(x));
        check({tag, "_by"}, 32'(by), 32'(y));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inputs change just after an edge and are held for a whole step period.
    task automatic step(input logic [1:0] pc, input logic wl);
        paddle_collision = pc;
        wall_collision   = wl;
        tick(STEP_DIV);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0);
    endtask

    task automatic do_serve();
        serve = 1'b1;
        tick(1);
        serve = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        check_pos("reset", 31, 31);
        check("reset_score1", 32'(score1), 0);
        check("reset_score2", 32'(score2), 0);
        check("reset_point1", 32'(point1), 0);
        check("reset_point2", 32'(point2), 0);
        check("reset_game_over", 32'(game_over), 0);
        check("reset_playing", 32'(playing), 0);

        // Serve and step timing
        do_serve();
        check("serve_playing", 32'(playing), 1);
        paddle_collision = 2'b00;
        wall_collision   = 1'b0;
        tick(3);
        check_pos("before_first_step", 31, 31);
        tick(1);
        check_pos("first_step", 32, 32);
        step(2'b00, 1'b0);
        check_pos("second_step", 33, 33);
        run(28);
        check_pos("reach_right", 61, 61);

        // Right paddle bounce, then held flag must not re-flip
        step(2'b11, 1'b0);
        check_pos("right_paddle", 60, 62);
        step(2'b11, 1'b0);
        check_pos("held_paddle", 59, 63);

        // Bottom wall bounce
        step(2'b00, 1'b1);
        check_pos("bottom_wall", 58, 62);
        run(56);
        check_pos("reach_left", 2, 6);

        // Left miss: player 2 scores
        step(2'b00, 1'b0);
        check("miss_left_point2", 32'(point2), 1);
        check("miss_left_point1", 32'(point1), 0);
        check("miss_left_score2", 32'(score2), 1);
        check("miss_left_playing", 32'(playing), 0);
        check_pos("miss_left_frozen", 2, 6);
        tick(1);
        check("point2_one_cycle", 32'(point2), 0);
        tick(7);
        check_pos("miss_delay_frozen", 2, 6);
        tick(4);
        check_pos("miss_left_recentre", 31, 31);
        check("miss_left_idle_playing", 32'(playing), 0);
        check("miss_left_idle_over", 32'(game_over), 0);

        // Serve toward the loser (left), left paddle, bottom wall, mid-field flip, corner
        do_serve();
        step(2'b00, 1'b0);
        check_pos("serve_left", 30, 32);
        run(28);
        check_pos("reach_left2", 2, 60);
        step(2'b01, 1'b0);
        check_pos("left_paddle", 3, 61);
        run(2);
        step(2'b00, 1'b1);
        check_pos("bottom_wall2", 6, 62);
        run(29);
        step(2'b11, 1'b0);
        check_pos("midfield_flip", 34, 32);
        run(32);
        check_pos("reach_corner", 2, 0);
        step(2'b01, 1'b1);
        check_pos("corner_bounce", 3, 1);

        // Right miss: player 1 scores first point
        run(58);
        check_pos("reach_right2", 61, 59);
        step(2'b00, 1'b0);
        check("miss_right_point1", 32'(point1), 1);
        check("miss_right_score1", 32'(score1), 1);
        tick(12);
        check_pos("miss_right_recentre", 31, 31);

        // Player 1 points 2..6
        for (int p = 2; p <= 6; p++) begin
            do_serve();
            run(30);
            check_pos("rally_right", 61, 61);
            step(2'b00, 1'b0);
            check("rally_score1", 32'(score1), 32'(p));
            check("rally_point1", 32'(point1), 1);
            tick(12);
            check("rally_idle_playing", 32'(playing), 0);
            check("rally_idle_over", 32'(game_over), 0);
        end

        // Seventh point, serve held through MISS is ignored
        do_serve();
        run(30);
        step(2'b00, 1'b0);
        check("final_score1", 32'(score1), 7);
        check("final_miss_over", 32'(game_over), 0);
        serve = 1'b1;
        tick(8);
        check_pos("serve_ignored_in_miss", 61, 61);
        check("serve_ignored_playing", 32'(playing), 0);
        tick(4);
        serve = 1'b0;
        check("game_over_set", 32'(game_over), 1);
        check("game_over_score1", 32'(score1), 7);
        check("game_over_score2", 32'(score2), 1);
        check_pos("game_over_centre", 31, 31);
        tick(3);
        check("game_over_holds", 32'(game_over), 1);

        // Serve from OVER clears scores and returns to IDLE
        do_serve();
        check("restart_game_over", 32'(game_over), 0);
        check("restart_score1", 32'(score1), 0);
        check("restart_score2", 32'(score2), 0);
        check("restart_idle", 32'(playing), 0);
        do_serve();
        check("restart_playing", 32'(playing), 1);
        step(2'b00, 1'b0);
        check_pos("restart_first_step", 32, 32);
        step(2'b00, 1'b0);

        // Asynchronous reset mid-play
        tick(2);
        rst_n = 1'b0;
        #1;
        check_pos("async_reset", 31, 31);
        check("async_reset_playing", 32'(playing), 0);
        check("async_reset_score1", 32'(score1), 0);
        check("async_reset_point1", 32'(point1), 0);
        check("async_reset_point2", 32'(point2), 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_pos("post_reset_idle", 31, 31);
        check("post_reset_playing", 32'(playing), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
